multicycle_control: RTL and testbench

Main control FSM for the multi-cycle MIPS CPU. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the 2-bit ALU operation code consumed by the ALU control decoder, and takes back that decoder's jump-register flag. It also handshakes with instruction/data memory through a ready signal so that memory wait states stall the sequence.

---
 rtl/multicycle_control_if.sv | 23 ++
 rtl/multicycle_control.sv | 102 ++++++++++
 tb/tb_multicycle_control.sv | 131 +++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control/status bundle between the multi-cycle FSM and the datapath.
// CNT_WIDTH sizes the performance counters.
interface multicycle_control_if #(parameter int CNT_WIDTH = 32);
   logic [5:0] opcode;
   logic jump_reg, mem_ready;
   logic pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
   logic reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;
   logic [CNT_WIDTH-1:0] cycle_count, instr_count;
   modport master (
      input opcode, jump_reg, mem_ready,
      output pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
      output reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
      output illegal, state, cycle_count, instr_count
   );
   modport slave (
      output opcode, jump_reg, mem_ready,
      input pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
      input reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
      input illegal, state, cycle_count, instr_count
   );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/memory/write-back sequencer for the multi-cycle MIPS core.
// Define MULTICYCLE_CONTROL_PERF_CNT_EN to build the cycle/instruction counters.
module multicycle_control (
   input logic clk,
   input logic reset,
   multicycle_control_if.master bus
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
      MEM_WR = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9
   } state_t;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BGT = 6'b000111, OP_J = 6'b000010;
   state_t st, nxt;
   logic pcw, pwc, irw, mrd, mwr, rw, ill, iod, rdst, m2r, asa;
   logic [1:0] asb, aop, psrc;
   always_ff @(posedge clk or posedge reset)
      if (reset) st <= FETCH;
      else st <= nxt;
   always_comb begin
      nxt = st;
      pcw = 1'b0; pwc = 1'b0; irw = 1'b0; mrd = 1'b0; mwr = 1'b0; rw = 1'b0; ill = 1'b0;
      iod = 1'b0; rdst = 1'b0; m2r = 1'b0; asa = 1'b0; asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         FETCH: begin
            mrd = 1'b1; asb = 2'b01; pcw = bus.mem_ready; irw = bus.mem_ready;
            nxt = bus.mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            asb = 2'b11;
            nxt = (bus.opcode == OP_R) ? R_EXEC :
                  (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEM_ADDR :
                  (bus.opcode == OP_BGT) ? BRANCH :
                  (bus.opcode == OP_J) ? JUMP : FETCH;
            ill = (nxt == FETCH);
         end
         MEM_ADDR: begin
            asa = 1'b1; asb = 2'b10;
            nxt = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mrd = 1'b1; iod = 1'b1;
            nxt = bus.mem_ready ? MEM_WB : MEM_RD;
         end
         MEM_WB: begin
            rw = 1'b1; m2r = 1'b1; nxt = FETCH;
         end
         MEM_WR: begin
            mwr = 1'b1; iod = 1'b1;
            nxt = bus.mem_ready ? FETCH : MEM_WR;
         end
         R_EXEC: begin
            asa = 1'b1; aop = 2'b10;
            pcw = bus.jump_reg; psrc = bus.jump_reg ? 2'b11 : 2'b00;
            nxt = bus.jump_reg ? FETCH : R_WB;
         end
         R_WB: begin
            aop = 2'b10; rw = 1'b1; rdst = 1'b1; nxt = FETCH;
         end
         BRANCH: begin
            asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; nxt = FETCH;
         end
         JUMP: begin
            pcw = 1'b1; psrc = 2'b10; nxt = FETCH;
         end
         default: nxt = FETCH;
      endcase
   end
   // Enables are gated by reset so nothing is written while reset is held.
   assign bus.pc_write = pcw & ~reset;
   assign bus.pc_write_cond = pwc & ~reset;
   assign bus.ir_write = irw & ~reset;
   assign bus.mem_read = mrd & ~reset;
   assign bus.mem_write = mwr & ~reset;
   assign bus.reg_write = rw & ~reset;
   assign bus.illegal = ill & ~reset;
   assign bus.i_or_d = iod;
   assign bus.reg_dst = rdst;
   assign bus.mem_to_reg = m2r;
   assign bus.alu_src_a = asa;
   assign bus.alu_src_b = asb;
   assign bus.alu_op = aop;
   assign bus.pc_source = psrc;
   assign bus.state = st;
`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
   localparam int W = $bits(bus.cycle_count);
   logic [W-1:0] cyc, ins;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cyc <= '0;
         ins <= '0;
      end else begin
         cyc <= cyc + W'(1);
         if (st == FETCH && bus.mem_ready) ins <= ins + W'(1);
      end
   assign bus.cycle_count = cyc;
   assign bus.instr_count = ins;
`else
   assign bus.cycle_count = '0;
   assign bus.instr_count = '0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle vectors feed a scoreboard queue; a negedge monitor checks state,
// control outputs and counters against the queued hand-computed expectations.
module tb_multicycle_control;
`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
   localparam int CW = 4;
`else
   localparam int CW = 32;
`endif
   typedef struct packed {
      logic [3:0] st;
      logic [16:0] ctl;
      logic [CW-1:0] cc, ic;
   } exp_t;
   // ctl order: pcw pwc irw mrd mwr iod rw rdst m2r asa asb[2] aop[2] psrc[2] ill
   localparam logic [16:0] FR   = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
   localparam logic [16:0] F0   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
   localparam logic [16:0] F1   = 17'b1_0_1_1_0_0_0_0_0_0_01_00_00_0;
   localparam logic [16:0] DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
   localparam logic [16:0] DECI = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
   localparam logic [16:0] MAD  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [16:0] MRD  = 17'b0_0_0_1_0_1_0_0_0_0_00_00_00_0;
   localparam logic [16:0] MWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
   localparam logic [16:0] MWR  = 17'b0_0_0_0_1_1_0_0_0_0_00_00_00_0;
   localparam logic [16:0] REX  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
   localparam logic [16:0] RJR  = 17'b1_0_0_0_0_0_0_0_0_1_00_10_11_0;
   localparam logic [16:0] RWB  = 17'b0_0_0_0_0_0_1_1_0_0_00_10_00_0;
   localparam logic [16:0] BR   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [16:0] JMP  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
   logic clk = 1'b0;
   logic reset = 1'b1;
   multicycle_control_if #(.CNT_WIDTH(CW)) bus();
   multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   exp_t q[$];
   exp_t m;
   int compared = 0;
   int mismatched = 0;
   logic [16:0] act;
   assign act = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read, bus.mem_write,
                 bus.i_or_d, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                 bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal};
`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
   logic [CW-1:0] cc_m = '0;
   logic [CW-1:0] ic_m = '0;
`endif
   task automatic step(input logic r, input logic [5:0] op, input logic jr, input logic rdy,
                       input logic [3:0] st, input logic [16:0] ctl);
      exp_t e;
      @(posedge clk);
      #1;
      reset = r;
      bus.opcode = op;
      bus.jump_reg = jr;
      bus.mem_ready = rdy;
      e.st = st;
      e.ctl = ctl;
`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
      if (r) begin
         cc_m = '0;
         ic_m = '0;
      end
      e.cc = cc_m;
      e.ic = ic_m;
      if (!r) cc_m = cc_m + CW'(1);
      if (!r && st == 4'd0 && rdy) ic_m = ic_m + CW'(1);
`else
      e.cc = '0;
      e.ic = '0;
`endif
      q.push_back(e);
   endtask
   always @(negedge clk)
      if (q.size() != 0) begin
         m = q.pop_front();
         compared++;
         if ({bus.state, act} !== {m.st, m.ctl}) begin
            mismatched++;
            $display("FAIL ctl: got state=%0d ctl=%b, want state=%0d ctl=%b", bus.state, act, m.st, m.ctl);
         end
         compared++;
         if ({bus.cycle_count, bus.instr_count} !== {m.cc, m.ic}) begin
            mismatched++;
            $display("FAIL cnt: got cycle=%0d instr=%0d, want cycle=%0d instr=%0d",
                     bus.cycle_count, bus.instr_count, m.cc, m.ic);
         end
      end
   initial begin
      bus.opcode = 6'd0;
      bus.jump_reg = 1'b0;
      bus.mem_ready = 1'b0;
      step(1, 0, 0, 0, 0, FR);
      step(1, 0, 0, 1, 0, FR);
      // R-type ADD
      step(0, 0, 0, 1, 0, F1); step(0, 0, 0, 1, 1, DEC); step(0, 0, 0, 1, 6, REX); step(0, 0, 0, 1, 7, RWB);
      // LW with three wait states in MEM_RD
      step(0, 35, 0, 1, 0, F1); step(0, 35, 0, 1, 1, DEC); step(0, 35, 0, 1, 2, MAD);
      for (int i = 0; i < 3; i++) step(0, 35, 0, 0, 3, MRD);
      step(0, 35, 0, 1, 3, MRD); step(0, 35, 0, 1, 4, MWB);
      // SW with one wait state
      step(0, 43, 0, 1, 0, F1); step(0, 43, 0, 1, 1, DEC); step(0, 43, 0, 1, 2, MAD);
      step(0, 43, 0, 0, 5, MWR); step(0, 43, 0, 1, 5, MWR);
      // BGT, JR, J, illegal
      step(0, 7, 0, 1, 0, F1); step(0, 7, 0, 1, 1, DEC); step(0, 7, 0, 1, 8, BR);
      step(0, 0, 1, 1, 0, F1); step(0, 0, 1, 1, 1, DEC); step(0, 0, 1, 1, 6, RJR);
      step(0, 2, 0, 1, 0, F1); step(0, 2, 0, 1, 1, DEC); step(0, 2, 0, 1, 9, JMP);
      step(0, 63, 0, 1, 0, F1); step(0, 63, 0, 1, 1, DECI);
      // FETCH wait state, then J
      step(0, 2, 0, 0, 0, F0); step(0, 2, 0, 1, 0, F1); step(0, 2, 0, 1, 1, DEC); step(0, 2, 0, 1, 9, JMP);
      // reset asserted while in MEM_RD
      step(0, 35, 0, 1, 0, F1); step(0, 35, 0, 1, 1, DEC); step(0, 35, 0, 1, 2, MAD);
      step(0, 35, 0, 0, 3, MRD); step(1, 35, 0, 1, 0, FR);
      step(0, 2, 0, 1, 0, F1); step(0, 2, 0, 1, 1, DEC); step(0, 2, 0, 1, 9, JMP);
      // 17 fetches after reset: instr_count wraps when the counter is 4 bits wide
      step(1, 63, 0, 1, 0, FR);
      for (int i = 0; i < 17; i++) begin
         step(0, 63, 0, 1, 0, F1);
         step(0, 63, 0, 1, 1, DECI);
      end
      step(0, 63, 0, 0, 0, F0);
      @(posedge clk);
      @(negedge clk);
      #1;
      compared++;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
